cc_rd_fill_multi_sm: RTL and testbench
======================================

// Module: cc_rd_fill_multi_sm
// PURPOSE
//  Command-dispatcher sub-FSM for CC_RD_FILL, generalised to NCHAN header FIFOs.
//  Selects one channel's 128-bit fill header, then sends CSN, CC, the 4 header words and DDR3 fill data over AXIS.
//  Adds held-valid AXIS handshake, an error code and a DDR3 readout watchdog.
//  Sits between the command dispatcher, the per-channel header FIFOs, ddr3_rd_control and the AXIS 2:1 mux.
// PARAMETERS
//  NCHAN        4    number of header FIFOs (1..16)
//  CHAN_W       2    width of chan_sel; 2**CHAN_W >= NCHAN
//  ADDR_W       23   DDR3 burst-address width
//  BCNT_W       21   burst-count width
//  EXTRA_BURSTS 2    bursts added to the header count (DDR3 header + footer)
//  WPB          4    32-bit words per 128-bit burst (power of 2)
//  TMO_W        24   watchdog width; timeout = 2**TMO_W-1 clk with no aurora_ddr3_accept
// PORTS
//  clk                      in  1            local clock
//  reset                    in  1            synchronous, active-high
//  run_sm                   in  1            enable; low forces IDLE
//  chan_sel                 in  CHAN_W       channel to read; sampled in IDLE
//  sm_running / sm_done     out 1 / 1        busy level / 1-clk completion pulse
//  tx_tvalid / tx_tlast     out 1 / 1        AXIS valid / last for CSN, CC and header words
//  tx_tready                in  1            AXIS ready
//  send_csn/send_cmd/send_inv_cmd/send_hdr out 1 each  one-hot word-source select
//  hdr_word                 out 32           header word driven while send_hdr=1
//  err_code                 out 2            0 ok, 1 bad chan, 2 FIFO empty, 3 timeout; held until next IDLE exit
//  fill_header_fifo_empty   in  NCHAN        per-channel FWFT empty
//  fill_header_fifo_rd_en   out NCHAN        one-hot pop, 1 clk
//  fill_header_fifo_out     in  NCHAN*128    channel c at [128c+127:128c]
//  fixed_ddr3_start_addr    in  ADDR_W       override start address
//  en_fixed_ddr3_start_addr in  1            use override
//  ddr3_rd_start_addr       out ADDR_W       first burst address
//  ddr3_rd_burst_cnt        out BCNT_W       bursts to read
//  enable_reading           out 1            level; high through DDR3 phase
//  reading_done             in  1            async; 2-flop synchronised internally
//  use_ddr3_data            out 1            mux selects DDR3 stream
//  aurora_ddr3_accept       in  1            one DDR3 word accepted
// BEHAVIOUR
//  Reset or run_sm=0: CS=IDLE next clk; all outputs 0, err_code 0, counters 0. No pop once aborted.
//  Registered outputs, decoded from NS. sm_running=0 only in IDLE.
//  IDLE -> CHK: latch chan_sel as ch, clear err_code.
//  CHK: ch>=NCHAN -> ERR(code 1); empty[ch] -> ERR(code 2); else -> HDR_LD.
//  HDR_LD (1 clk): rd_en[ch]=1; latch header H;
//    ddr3_rd_start_addr = en_fixed ? fixed : H[57:35];
//    ddr3_rd_burst_cnt = H[84:64]+EXTRA_BURSTS (BCNT_W bits, wraps);
//    words_left = burst_cnt*WPB (BCNT_W+log2(WPB) bits). -> CSN.
//  ERR (1 clk) -> CSN.
//  AXIS rule: tvalid rises with the word; word, select and tlast held stable until tvalid&tready;
//    tvalid is never dropped before acceptance.
//  CSN: send_csn=1, tvalid=1; on accept -> CC.
//  CC: send_cmd (ok) or send_inv_cmd (err), tvalid=1; error: tlast=1, on accept -> DONE;
//    ok: on accept -> HW with idx=0.
//  HW: send_hdr=1, hdr_word=H[32*idx+31:32*idx], tvalid=1; accept of idx 3 -> DDR3; else idx+1.
//  DDR3: enable_reading=1, use_ddr3_data=1, tvalid=0;
//    each aurora_ddr3_accept decrements words_left (saturate at 0) and clears the watchdog;
//    exit to DONE when reading_done_sync2=1 and words_left==0 (compare registered, 1 clk lag);
//    watchdog at max -> DONE, err_code=3, enable_reading and use_ddr3_data drop at DONE.
//  DONE (1 clk): sm_done=1; use_ddr3_data=1 only if err_code==0. -> IDLE.
//  Accept and done in the same clk: the decrement applies before the exit compare of the next clk.
//  burst count 0 from header: still EXTRA_BURSTS*WPB words.
// TESTING
//  NCHAN=4, ch2 holds H with [84:64]=10, [57:35]=0x1234 -> burst_cnt 12, addr 0x1234, rd_en=4'b0100 once,
//    CSN, CC, 4 H words, 48 accepts, sm_done.
//  chan_sel=2, empty[2]=1 -> CSN then ~CC with tlast, err_code=2, no rd_en, no enable_reading.
//  chan_sel=5 (NCHAN=4) -> err_code=1 response, no FIFO pop.
//  tx_tready low 7 clk during HW idx1 -> tvalid and hdr_word held; exactly 4 header beats total.
//  TMO_W=4, no accepts in DDR3 -> DONE after 15 clk, err_code=3, sm_done pulse.
//  run_sm low mid-HW and in DDR3 -> IDLE next clk, all outputs 0; reset mid-CC same.

Source files
------------

// File: rtl/cc_rd_fill_multi_sm.sv
// Purpose: CC_RD_FILL dispatcher sub-FSM; pops one channel's 128-bit fill header, sends CSN, CC, 4 header words, then hands AXIS to DDR3 data.
// Latency: header pop 2 clk after leaving IDLE, CSN beat 1 clk later; every output is registered and decoded from the next state.
// Backpressure: CSN/CC/header beats are held (word, select, tlast, tvalid) until tvalid&tready; DDR3 phase is paced by aurora_ddr3_accept with a watchdog.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   run_sm, chan_sel                 enable (low aborts to IDLE), channel to read (sampled in IDLE)
//   sm_running, sm_done, err_code    busy level, 1-clk completion pulse, 0 ok / 1 bad chan / 2 empty / 3 timeout
//   tx_tvalid, tx_tlast, tx_tready   AXIS handshake for CSN, CC and header words
//   send_csn/cmd/inv_cmd/hdr         one-hot word-source select, hdr_word is the header word while send_hdr
//   fill_header_fifo_*               per-channel FWFT empty, one-hot pop, packed 128-bit headers
//   fixed_ddr3_start_addr, en_fixed  start-address override
//   ddr3_rd_start_addr/burst_cnt     read request to ddr3_rd_control
//   enable_reading, reading_done     DDR3 phase level, asynchronous completion from the reader
//   use_ddr3_data, aurora_ddr3_accept  AXIS mux select, one DDR3 word accepted downstream
module cc_rd_fill_multi_sm #(
  parameter int NCHAN        = 4,
  parameter int CHAN_W       = 2,
  parameter int ADDR_W       = 23,
  parameter int BCNT_W       = 21,
  parameter int EXTRA_BURSTS = 2,
  parameter int WPB          = 4,
  parameter int TMO_W        = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_sm,
  input  logic [CHAN_W-1:0]     chan_sel,
  output logic                  sm_running,
  output logic                  sm_done,
  output logic                  tx_tvalid,
  output logic                  tx_tlast,
  input  logic                  tx_tready,
  output logic                  send_csn,
  output logic                  send_cmd,
  output logic                  send_inv_cmd,
  output logic                  send_hdr,
  output logic [31:0]           hdr_word,
  output logic [1:0]            err_code,
  input  logic [NCHAN-1:0]      fill_header_fifo_empty,
  output logic [NCHAN-1:0]      fill_header_fifo_rd_en,
  input  logic [NCHAN*128-1:0]  fill_header_fifo_out,
  input  logic [ADDR_W-1:0]     fixed_ddr3_start_addr,
  input  logic                  en_fixed_ddr3_start_addr,
  output logic [ADDR_W-1:0]     ddr3_rd_start_addr,
  output logic [BCNT_W-1:0]     ddr3_rd_burst_cnt,
  output logic                  enable_reading,
  input  logic                  reading_done,
  output logic                  use_ddr3_data,
  input  logic                  aurora_ddr3_accept
);

  localparam int WPB_LG = $clog2(WPB);
  localparam int WL_W   = BCNT_W + WPB_LG;
  // One below all-ones: the exit fires on the edge where the counter would
  // reach its maximum, giving exactly 2**TMO_W-1 quiet cycles in DDR3.
  localparam logic [TMO_W-1:0] WD_LAST = {TMO_W{1'b1}} - 1'b1;

  typedef enum logic [3:0] {
    S_IDLE, S_CHK, S_HDR_LD, S_ERR, S_CSN, S_CC, S_HW, S_DDR3, S_DONE
  } state_t;

  state_t            cs, ns;
  logic [CHAN_W-1:0] ch;
  logic [127:0]      hdr;
  logic [1:0]        idx, idx_n;
  logic [1:0]        err_n;
  logic [WL_W-1:0]   words_left;
  logic [TMO_W-1:0]  wd_cnt;
  logic              rd_done_s1, rd_done_s2;

  logic              chan_ok;
  logic              sel_empty;
  logic [127:0]      sel_hdr;
  logic [BCNT_W-1:0] bcnt_calc;
  logic [WL_W-1:0]   words_init;
  logic              beat_acc;

  assign beat_acc = tx_tvalid & tx_tready;

  // Channel mux by comparison so an out-of-range ch never indexes past NCHAN.
  always_comb begin
    chan_ok   = 1'b0;
    sel_empty = 1'b1;
    sel_hdr   = '0;
    for (int c = 0; c < NCHAN; c++) begin
      if (ch == CHAN_W'(c)) begin
        chan_ok   = 1'b1;
        sel_empty = fill_header_fifo_empty[c];
        sel_hdr   = fill_header_fifo_out[128*c +: 128];
      end
    end
  end

  // Header count plus the DDR3 header/footer bursts; wraps at BCNT_W bits.
  assign bcnt_calc  = BCNT_W'(sel_hdr[84:64]) + BCNT_W'(EXTRA_BURSTS);
  assign words_init = WL_W'(bcnt_calc) << WPB_LG;

  always_comb begin
    ns    = cs;
    idx_n = idx;
    err_n = err_code;
    case (cs)
      S_IDLE: begin
        ns    = S_CHK;
        err_n = 2'd0;
      end
      S_CHK: begin
        if (!chan_ok) begin
          ns    = S_ERR;
          err_n = 2'd1;
        end else if (sel_empty) begin
          ns    = S_ERR;
          err_n = 2'd2;
        end else begin
          ns = S_HDR_LD;
        end
      end
      S_HDR_LD: ns = S_CSN;
      S_ERR:    ns = S_CSN;
      S_CSN: begin
        if (beat_acc) ns = S_CC;
      end
      S_CC: begin
        if (beat_acc) begin
          if (err_code != 2'd0) begin
            ns = S_DONE;
          end else begin
            ns    = S_HW;
            idx_n = 2'd0;
          end
        end
      end
      S_HW: begin
        if (beat_acc) begin
          if (idx == 2'd3) ns = S_DDR3;
          else             idx_n = idx + 2'd1;
        end
      end
      S_DDR3: begin
        // words_left is the registered count, so an accept in the same clk
        // as reading_done is only seen by the compare one clk later.
        if (rd_done_s2 && (words_left == '0)) begin
          ns = S_DONE;
        end else if (!aurora_ddr3_accept && (wd_cnt == WD_LAST)) begin
          ns    = S_DONE;
          err_n = 2'd3;
        end
      end
      S_DONE:  ns = S_IDLE;
      default: ns = S_IDLE;
    endcase
    if (!run_sm) begin
      ns    = S_IDLE;
      err_n = 2'd0;
      idx_n = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs                     <= S_IDLE;
      ch                     <= '0;
      hdr                    <= '0;
      idx                    <= '0;
      err_code               <= '0;
      words_left             <= '0;
      wd_cnt                 <= '0;
      rd_done_s1             <= 1'b0;
      rd_done_s2             <= 1'b0;
      sm_running             <= 1'b0;
      sm_done                <= 1'b0;
      tx_tvalid              <= 1'b0;
      tx_tlast               <= 1'b0;
      send_csn               <= 1'b0;
      send_cmd               <= 1'b0;
      send_inv_cmd           <= 1'b0;
      send_hdr               <= 1'b0;
      hdr_word               <= '0;
      fill_header_fifo_rd_en <= '0;
      ddr3_rd_start_addr     <= '0;
      ddr3_rd_burst_cnt      <= '0;
      enable_reading         <= 1'b0;
      use_ddr3_data          <= 1'b0;
    end else begin
      cs         <= ns;
      idx        <= idx_n;
      err_code   <= err_n;
      rd_done_s1 <= reading_done;
      rd_done_s2 <= rd_done_s1;

      if (cs == S_IDLE && ns == S_CHK) ch <= chan_sel;

      if (ns == S_IDLE) begin
        hdr                <= '0;
        ddr3_rd_start_addr <= '0;
        ddr3_rd_burst_cnt  <= '0;
      end else if (cs == S_HDR_LD) begin
        hdr                <= sel_hdr;
        ddr3_rd_start_addr <= en_fixed_ddr3_start_addr ? fixed_ddr3_start_addr
                                                       : ADDR_W'(sel_hdr[57:35]);
        ddr3_rd_burst_cnt  <= bcnt_calc;
      end

      if (ns == S_IDLE) begin
        words_left <= '0;
      end else if (cs == S_HDR_LD) begin
        words_left <= words_init;
      end else if (cs == S_DDR3 && aurora_ddr3_accept && (words_left != '0)) begin
        words_left <= words_left - 1'b1;
      end

      if (cs == S_DDR3 && ns == S_DDR3) begin
        wd_cnt <= aurora_ddr3_accept ? '0 : wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end

      // Outputs decoded from ns so they change together with the state.
      sm_running             <= (ns != S_IDLE);
      sm_done                <= (ns == S_DONE);
      tx_tvalid              <= (ns == S_CSN) || (ns == S_CC) || (ns == S_HW);
      tx_tlast               <= (ns == S_CC) && (err_n != 2'd0);
      send_csn               <= (ns == S_CSN);
      send_cmd               <= (ns == S_CC) && (err_n == 2'd0);
      send_inv_cmd           <= (ns == S_CC) && (err_n != 2'd0);
      send_hdr               <= (ns == S_HW);
      hdr_word               <= (ns == S_HW) ? hdr[32*idx_n +: 32] : 32'd0;
      fill_header_fifo_rd_en <= (ns == S_HDR_LD) ? (NCHAN'(1) << ch) : '0;
      enable_reading         <= (ns == S_DDR3);
      use_ddr3_data          <= (ns == S_DDR3) || ((ns == S_DONE) && (err_n == 2'd0));
    end
  end

endmodule

// File: tb/tb_cc_rd_fill_multi_sm.sv
// Directed bench for cc_rd_fill_multi_sm: normal read, empty and bad-channel
// errors, AXIS stall, fixed address with zero burst count, watchdog, aborts.
module tb_cc_rd_fill_multi_sm;

  localparam int NCHAN  = 4;
  localparam int CHAN_W = 3;
  localparam int ADDR_W = 23;
  localparam int BCNT_W = 21;
  localparam int TMO_W  = 4;

  logic                 clk;
  logic                 reset;
  logic                 run_sm;
  logic [CHAN_W-1:0]    chan_sel;
  logic                 sm_running, sm_done;
  logic                 tx_tvalid, tx_tlast, tx_tready;
  logic                 send_csn, send_cmd, send_inv_cmd, send_hdr;
  logic [31:0]          hdr_word;
  logic [1:0]           err_code;
  logic [NCHAN-1:0]     fill_header_fifo_empty;
  logic [NCHAN-1:0]     fill_header_fifo_rd_en;
  logic [NCHAN*128-1:0] fill_header_fifo_out;
  logic [ADDR_W-1:0]    fixed_ddr3_start_addr;
  logic                 en_fixed_ddr3_start_addr;
  logic [ADDR_W-1:0]    ddr3_rd_start_addr;
  logic [BCNT_W-1:0]    ddr3_rd_burst_cnt;
  logic                 enable_reading, reading_done, use_ddr3_data, aurora_ddr3_accept;

  cc_rd_fill_multi_sm #(
    .NCHAN(NCHAN), .CHAN_W(CHAN_W), .ADDR_W(ADDR_W), .BCNT_W(BCNT_W),
    .EXTRA_BURSTS(2), .WPB(4), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .reset(reset), .run_sm(run_sm), .chan_sel(chan_sel),
    .sm_running(sm_running), .sm_done(sm_done),
    .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
    .send_csn(send_csn), .send_cmd(send_cmd), .send_inv_cmd(send_inv_cmd), .send_hdr(send_hdr),
    .hdr_word(hdr_word), .err_code(err_code),
    .fill_header_fifo_empty(fill_header_fifo_empty),
    .fill_header_fifo_rd_en(fill_header_fifo_rd_en),
    .fill_header_fifo_out(fill_header_fifo_out),
    .fixed_ddr3_start_addr(fixed_ddr3_start_addr),
    .en_fixed_ddr3_start_addr(en_fixed_ddr3_start_addr),
    .ddr3_rd_start_addr(ddr3_rd_start_addr), .ddr3_rd_burst_cnt(ddr3_rd_burst_cnt),
    .enable_reading(enable_reading), .reading_done(reading_done),
    .use_ddr3_data(use_ddr3_data), .aurora_ddr3_accept(aurora_ddr3_accept)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Event counters sampled on the active edge (pre-update values = handshakes).
  int n_csn = 0, n_cmd = 0, n_inv = 0, n_hdr = 0, n_pop = 0, n_en = 0;
  logic [NCHAN-1:0] last_pop = '0;
  logic [31:0] hdr_q[$];

  always @(posedge clk) begin
    if (tx_tvalid && tx_tready) begin
      if (send_csn)     n_csn <= n_csn + 1;
      if (send_cmd)     n_cmd <= n_cmd + 1;
      if (send_inv_cmd) n_inv <= n_inv + 1;
      if (send_hdr) begin
        n_hdr <= n_hdr + 1;
        hdr_q.push_back(hdr_word);
      end
    end
    if (fill_header_fifo_rd_en != '0) begin
      n_pop    <= n_pop + 1;
      last_pop <= fill_header_fifo_rd_en;
    end
    if (enable_reading) n_en <= n_en + 1;
  end

  initial begin
    #100000;
    $display("FAIL sim_time_limit: observed run still active, expected summary");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] outs_vec();
    return {36'd0, sm_running, sm_done, tx_tvalid, tx_tlast, send_csn, send_cmd,
            send_inv_cmd, send_hdr, hdr_word, err_code, fill_header_fifo_rd_en,
            ddr3_rd_start_addr, ddr3_rd_burst_cnt, enable_reading, use_ddr3_data};
  endfunction

  task automatic wait_en(input int max, input string tag);
    int n = 0;
    while (!enable_reading && n < max) begin
      tick();
      n++;
    end
    chk(tag, enable_reading, 1'b1);
  endtask

  task automatic wait_done(input int max, input string tag);
    int n = 0;
    while (!sm_done && n < max) begin
      tick();
      n++;
    end
    chk(tag, sm_done, 1'b1);
  endtask

  logic [127:0] H [NCHAN];
  int b_pop, b_hdr, b_csn, b_cmd, b_inv, b_en;

  initial begin
    for (int c = 0; c < NCHAN; c++) begin
      H[c] = {32'hDEAD_0000 + 32'(c), 32'hC0DE_0000 + 32'(c),
              32'hB0B0_0000 + 32'(c), 32'hA5A5_0000 + 32'(c)};
    end
    H[2][84:64] = 21'd10;
    H[2][57:35] = 23'h1234;
    H[1][84:64] = 21'd0;
    H[3][84:64] = 21'd5;
    for (int c = 0; c < NCHAN; c++) fill_header_fifo_out[128*c +: 128] = H[c];

    reset = 1'b1; run_sm = 1'b0; chan_sel = '0; tx_tready = 1'b1;
    fill_header_fifo_empty = '1; fixed_ddr3_start_addr = '0;
    en_fixed_ddr3_start_addr = 1'b0; reading_done = 1'b0; aurora_ddr3_accept = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("reset_outputs", outs_vec(), 128'd0);

    // ---- normal read of channel 2, with a 7-clk stall on header word 1 ----
    b_pop = n_pop; b_hdr = n_hdr; b_csn = n_csn; b_cmd = n_cmd;
    fill_header_fifo_empty = 4'b1011;
    chan_sel = 3'd2;
    run_sm = 1'b1;
    tick();
    chk("ok_chk_running", {sm_running, tx_tvalid}, 2'b10);
    tick();
    chk("ok_rd_en", fill_header_fifo_rd_en, 4'b0100);
    tick();
    chk("ok_csn", {send_csn, tx_tvalid, send_cmd, send_hdr, fill_header_fifo_rd_en}, 8'b1100_0000);
    chk("ok_addr", ddr3_rd_start_addr, 23'h1234);
    chk("ok_bcnt", ddr3_rd_burst_cnt, 21'd12);
    tick();
    chk("ok_cc", {send_cmd, send_inv_cmd, tx_tlast, tx_tvalid, send_csn}, 5'b10010);
    tick();
    chk("ok_hw0", {send_hdr, tx_tvalid, hdr_word}, {2'b11, H[2][31:0]});
    tick();
    chk("ok_hw1", {send_hdr, tx_tvalid, hdr_word}, {2'b11, H[2][63:32]});
    tx_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("stall_hold", {send_hdr, tx_tvalid, hdr_word}, {2'b11, H[2][63:32]});
    end
    tx_tready = 1'b1;
    wait_en(10, "ok_reach_ddr3");
    chk("ok_ddr3_outs", {use_ddr3_data, tx_tvalid, send_hdr}, 3'b100);
    chk("ok_hdr_beats", n_hdr - b_hdr, 4);
    for (int i = 0; i < 4; i++) chk("ok_hdr_word", hdr_q[b_hdr + i], H[2][32*i +: 32]);
    chk("ok_csn_cmd_beats", {n_csn - b_csn, n_cmd - b_cmd}, {32'd1, 32'd1});
    chk("ok_pop_once", {n_pop - b_pop, last_pop}, {32'd1, 4'b0100});
    reading_done = 1'b1;
    for (int i = 0; i < 47; i++) begin
      aurora_ddr3_accept = 1'b1;
      tick();
    end
    aurora_ddr3_accept = 1'b0;
    tick(); tick();
    chk("ok_47_not_done", {enable_reading, sm_done}, 2'b10);
    aurora_ddr3_accept = 1'b1;
    tick();
    aurora_ddr3_accept = 1'b0;
    tick();
    chk("ok_done", {sm_done, err_code, use_ddr3_data, enable_reading, tx_tvalid}, 6'b1_00_100);
    run_sm = 1'b0; reading_done = 1'b0;
    tick();
    chk("ok_idle", outs_vec(), 128'd0);

    // ---- channel 2 empty -> error 2 ----
    b_pop = n_pop; b_en = n_en;
    fill_header_fifo_empty = 4'b0100;
    run_sm = 1'b1;
    tick(); tick();
    chk("empty_err", {err_code, fill_header_fifo_rd_en, tx_tvalid}, {2'd2, 4'b0000, 1'b0});
    tick();
    chk("empty_csn", {send_csn, tx_tvalid}, 2'b11);
    tick();
    chk("empty_cc", {send_cmd, send_inv_cmd, tx_tlast, tx_tvalid}, 4'b0111);
    tick();
    chk("empty_done", {sm_done, err_code, use_ddr3_data, enable_reading}, 5'b1_10_00);
    chk("empty_no_pop_no_read", {n_pop - b_pop, n_en - b_en}, 64'd0);
    run_sm = 1'b0;
    tick();
    chk("empty_abort_clears_err", err_code, 2'd0);

    // ---- channel 5 out of range -> error 1 ----
    b_pop = n_pop; b_inv = n_inv;
    fill_header_fifo_empty = 4'b0000;
    chan_sel = 3'd5;
    run_sm = 1'b1;
    tick(); tick();
    chk("badch_err", err_code, 2'd1);
    wait_done(10, "badch_done");
    chk("badch_resp", {err_code, n_inv - b_inv, n_pop - b_pop}, {2'd1, 32'd1, 32'd0});
    run_sm = 1'b0;
    tick();

    // ---- channel 1, fixed address, header burst count 0 -> 8 words ----
    en_fixed_ddr3_start_addr = 1'b1;
    fixed_ddr3_start_addr = 23'h7ABCD;
    chan_sel = 3'd1;
    run_sm = 1'b1;
    tick(); tick(); tick();
    chk("fix_addr_cnt", {ddr3_rd_start_addr, ddr3_rd_burst_cnt}, {23'h7ABCD, 21'd2});
    wait_en(10, "fix_reach_ddr3");
    reading_done = 1'b1;
    for (int i = 0; i < 7; i++) begin
      aurora_ddr3_accept = 1'b1;
      tick();
    end
    aurora_ddr3_accept = 1'b0;
    tick(); tick();
    chk("fix_7_not_done", {enable_reading, sm_done}, 2'b10);
    aurora_ddr3_accept = 1'b1;
    tick();
    aurora_ddr3_accept = 1'b0;
    tick();
    chk("fix_done", {sm_done, err_code, use_ddr3_data}, 4'b1_00_1);
    run_sm = 1'b0; reading_done = 1'b0; en_fixed_ddr3_start_addr = 1'b0;
    tick();

    // ---- channel 3, no accepts -> watchdog after 15 clk ----
    b_en = n_en;
    chan_sel = 3'd3;
    run_sm = 1'b1;
    wait_done(40, "tmo_done");
    chk("tmo_cycles", n_en - b_en, 15);
    chk("tmo_outs", {err_code, use_ddr3_data, enable_reading}, 4'b11_00);
    run_sm = 1'b0;
    tick();

    // ---- aborts: at CHK, mid-HW, in DDR3; reset mid-CC ----
    b_pop = n_pop;
    chan_sel = 3'd2;
    fill_header_fifo_empty = 4'b1011;
    run_sm = 1'b1;
    tick();
    run_sm = 1'b0;
    tick();
    chk("abort_chk_outs", outs_vec(), 128'd0);
    tick();
    chk("abort_chk_no_pop", n_pop - b_pop, 0);

    run_sm = 1'b1;
    repeat (5) tick();
    chk("abort_hw_in_hw", send_hdr, 1'b1);
    run_sm = 1'b0;
    tick();
    chk("abort_hw_outs", outs_vec(), 128'd0);

    run_sm = 1'b1;
    wait_en(15, "abort_ddr3_reach");
    run_sm = 1'b0;
    tick();
    chk("abort_ddr3_outs", outs_vec(), 128'd0);

    run_sm = 1'b1;
    repeat (4) tick();
    chk("reset_cc_in_cc", send_cmd, 1'b1);
    reset = 1'b1;
    tick();
    chk("reset_cc_outs", outs_vec(), 128'd0);
    reset = 1'b0; run_sm = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
